// File: rtl/sum_window_accumulator.sv
// Windowed accumulator for the adder sum stream: sums WINDOW samples,
// saturating at ACC_W bits, and holds the result on a valid/ready port.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready (sample
// input); clear (sync window abort); out_data/out_valid/out_ready/out_sat
// (held window result plus sticky saturation flag).
// Build option: define SUM_AVG_EN to emit sum >> log2(WINDOW) instead of
// the raw sum (WINDOW must then be a power of two).
module sum_window_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat
);

  localparam int CNT_W = 8;
  localparam int EXT_W = ACC_W + 1;

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  localparam logic [ACC_W-1:0] MAX  = '1;

  if (ACC_W < DATA_W) begin : g_bad_acc_w
    $error("ACC_W must be >= DATA_W");
  end
  if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
    $error("WINDOW must be in 1..255");
  end

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [ACC_W-1:0] out_q;
  logic             out_sat_q;

  logic [EXT_W-1:0] sum_ext;
  logic             ovf;
  logic [ACC_W-1:0] nxt_acc;
  logic             nxt_sat;
  logic [ACC_W-1:0] res;

  // One spare carry bit detects overflow of the running total.
  always_comb begin
    sum_ext = {1'b0, acc} + EXT_W'(in_data);
    ovf     = sum_ext[ACC_W];
    nxt_acc = ovf ? MAX : sum_ext[ACC_W-1:0];
    nxt_sat = sat | ovf;
  end

`ifdef SUM_AVG_EN
  localparam int SHIFT = $clog2(WINDOW);

  if ((WINDOW & (WINDOW - 1)) != 0) begin : g_bad_avg
    $error("SUM_AVG_EN needs a power-of-two WINDOW");
  end

  always_comb begin
    res = nxt_acc >> SHIFT;
  end
`else
  always_comb begin
    res = nxt_acc;
  end
`endif

  assign in_ready  = (state == S_ACC) && !rst;
  assign out_valid = (state == S_OUT);
  assign out_data  = out_q;
  assign out_sat   = out_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_q     <= '0;
      out_sat_q <= 1'b0;
    end else if (clear) begin
      state <= S_ACC;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else if (state == S_OUT) begin
      if (out_ready) begin
        state <= S_ACC;
        acc   <= '0;
        cnt   <= '0;
        sat   <= 1'b0;
      end
    end else if (in_valid) begin
      if (cnt == LAST) begin
        state     <= S_OUT;
        out_q     <= res;
        out_sat_q <= nxt_sat;
        acc       <= nxt_acc;
        cnt       <= cnt + CNT_W'(1);
        sat       <= nxt_sat;
      end else begin
        acc <= nxt_acc;
        cnt <= cnt + CNT_W'(1);
        sat <= nxt_sat;
      end
    end
  end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Bench for sum_window_accumulator (ACC_W=9, WINDOW=4): vector table,
// corner sequences and random traffic against a queue-based model.
module tb_sum_window_accumulator;

  localparam int DW   = 8;
  localparam int AW   = 9;
  localparam int WIN  = 4;
  localparam int MAXV = (1 << AW) - 1;
`ifdef SUM_AVG_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          clear = 1'b0;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sat;

  always #5 clk = ~clk;

  sum_window_accumulator #(
    .DATA_W(DW),
    .ACC_W (AW),
    .WINDOW(WIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sat  (out_sat)
  );

  int total = 0;
  int bad   = 0;

  bit m_out  = 1'b0;
  int m_win[$];
  int m_data = 0;
  bit m_sat  = 1'b0;

  typedef struct {
    bit r;
    bit v;
    int d;
    bit ordy;
    bit clr;
    bit er;
    bit ev;
    int ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Window semantics: the result is the clamped plain sum of the
  // window's samples; saturation means that plain sum exceeded MAXV.
  task automatic model(bit r, bit v, int d, bit ordy, bit clr);
    int s;
    if (r) begin
      m_out = 0;
      m_win.delete();
      m_data = 0;
      m_sat = 0;
    end else if (clr) begin
      m_out = 0;
      m_win.delete();
    end else if (m_out) begin
      if (ordy) m_out = 0;
    end else if (v) begin
      m_win.push_back(d);
      if (m_win.size() == WIN) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_sat = (s > MAXV);
        m_data = (m_sat ? MAXV : s) >> SH;
        m_out = 1;
        m_win.delete();
      end
    end
  endtask

  task automatic cyc(bit r, bit v, int d, bit ordy, bit clr);
    rst = r;
    in_valid = v;
    in_data = DW'(d);
    out_ready = ordy;
    clear = clr;
    @(posedge clk);
    model(r, v, d, ordy, clr);
    #1;
    chk("in_ready", in_ready, (!m_out && !r));
    chk("out_valid", out_valid, m_out);
    chk("out_data", out_data, m_data);
    if (m_out) chk("out_sat", out_sat, m_sat);
  endtask

  task automatic win4(int a, int b, int c, int d);
    cyc(0, 1, a, 0, 0);
    cyc(0, 1, b, 0, 0);
    cyc(0, 1, c, 0, 0);
    cyc(0, 1, d, 0, 0);
  endtask

  function automatic vec_t mk(bit r, bit v, int d, bit ordy, bit clr,
                              bit er, bit ev, int ed);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.ordy = ordy; t.clr = clr;
    t.er = er; t.ev = ev; t.ed = ed;
    return t;
  endfunction

  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 10, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 20, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 30, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 40, 1, 0, 0, 1, 100 >> SH));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 99, 0, 0, 0, 1, 100 >> SH));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 100 >> SH));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 100 >> SH));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 4 >> SH));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4 >> SH));

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      chk("tbl_ready", in_ready, tbl[i].er);
      chk("tbl_valid", out_valid, tbl[i].ev);
      chk("tbl_data", out_data, tbl[i].ed);
      if (tbl[i].ev) chk("tbl_sat", out_sat, 0);
    end

    win4(200, 200, 200, 200);
    chk("sat_data", out_data, MAXV >> SH);
    chk("sat_flag", out_sat, 1);
    cyc(0, 0, 0, 1, 0);
    win4(1, 2, 3, 4);
    chk("unsat_data", out_data, 10 >> SH);
    chk("unsat_flag", out_sat, 0);
    cyc(0, 0, 0, 1, 0);

    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 5, 0, 1);
    chk("clr_ready", in_ready, 1);
    win4(7, 7, 7, 7);
    chk("clr_data", out_data, 28 >> SH);
    chk("clr_valid", out_valid, 1);
    cyc(0, 0, 0, 1, 0);

    win4(10, 20, 30, 40);
    chk("pre_rst_data", out_data, 100 >> SH);
    cyc(1, 0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    cyc(0, 0, 0, 0, 0);
    win4(1, 2, 3, 4);
    chk("post_rst_data", out_data, 10 >> SH);
    cyc(0, 0, 0, 1, 0);

    win4(10, 20, 30, 41);
    chk("avg_data", out_data, 101 >> SH);
    chk("avg_sat", out_sat, 0);
    cyc(0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
